// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port synchronous-read data RAM between the core MEM stage and a debug/loader master
//   clk, rst (async active-low)
//   core_req/we/addr/wdata/ubhw -> core_stall, core_rvalid, core_rdata
//   dbg_req/we/addr/wdata       -> dbg_gnt, dbg_rvalid, dbg_rdata
//   ram_addr/wdata/we/ubhw      <- winner mux; ram_rdata returns one cycle later
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [2:0]        core_ubhw,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic [2:0]        ram_ubhw,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic [1:0] {NONE, CORE, DBG} owner_t;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  owner_t owner, owner_nxt;
  logic [7:0] starve_cnt, starve_nxt;
  logic core_win, dbg_win;
  // Winners are gated by rst so the RAM sees no strobe and no handshake fires while in reset.
  always_comb begin
    dbg_win     = rst && dbg_req && (!core_req || starve_cnt == LIMIT);
    core_win    = rst && core_req && !dbg_win;
    core_stall  = rst && core_req && !core_win;
    dbg_gnt     = dbg_win;
    ram_addr    = core_win ? core_addr : dbg_win ? dbg_addr : '0;
    ram_wdata   = core_win ? core_wdata : dbg_win ? dbg_wdata : '0;
    ram_we      = core_win ? core_we : dbg_win && dbg_we;
    ram_ubhw    = core_win ? core_ubhw : 3'b010;
    starve_nxt  = (dbg_req && !dbg_win) ? ((starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 8'd1) : 8'd0;
    owner_nxt   = (core_win && !core_we) ? CORE : (dbg_win && !dbg_we) ? DBG : NONE;
    core_rvalid = owner == CORE;
    dbg_rvalid  = owner == DBG;
    core_rdata  = core_rvalid ? ram_rdata : '0;
    dbg_rdata   = dbg_rvalid ? ram_rdata : '0;
  end
  // Clearing owner asynchronously drops any in-flight read response immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= NONE;
      starve_cnt <= '0;
    end else begin
      owner      <= owner_nxt;
      starve_cnt <= starve_nxt;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with directed vectors
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, core_stall, core_rvalid;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [2:0]  core_ubhw, ram_ubhw;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we;
  logic        wr_ok = 1'b0;
  logic [31:0] wr_addr, wr_data;
  typedef struct packed {logic is_dbg; logic [31:0] data;} resp_t;
  resp_t sb[$];
  int checks = 0;
  int failures = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ubhw(core_ubhw), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_ubhw(ram_ubhw),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: unwritten words read as {16'hBEEF, addr[15:0]}; remembers the last written word.
  always @(posedge clk) begin
    if (ram_we) begin
      wr_ok   <= 1'b1;
      wr_addr <= ram_addr;
      wr_data <= ram_wdata;
    end
    ram_rdata <= (wr_ok && wr_addr == ram_addr) ? wr_data : {16'hBEEF, ram_addr[15:0]};
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    resp_t e;
    if (core_rvalid || dbg_rvalid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid actual core=%0b dbg=%0b required none", core_rvalid, dbg_rvalid);
      end else begin
        e = sb.pop_front();
        chk("rv_core", 32'(core_rvalid), 32'(!e.is_dbg));
        chk("rv_dbg", 32'(dbg_rvalid), 32'(e.is_dbg));
        chk("rv_data", e.is_dbg ? dbg_rdata : core_rdata, e.data);
      end
    end
  end

  task automatic idle();
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0; core_ubhw = 3'b010;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 0;
    idle();
    core_req = 1; core_we = 1; core_addr = 32'h10; dbg_req = 1; dbg_we = 1;
    #2;
    mid();
    chk("rst_stall", 32'(core_stall), 0);
    chk("rst_gnt", 32'(dbg_gnt), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_crv", 32'(core_rvalid), 0);
    chk("rst_drv", 32'(dbg_rvalid), 0);
    next();
    idle();
    rst = 1;
    mid();
    chk("idle_addr", ram_addr, 0);
    chk("idle_ubhw", 32'(ram_ubhw), 32'h2);
    next();
    // core read alone
    core_req = 1; core_addr = 32'h10; core_ubhw = 3'b100;
    sb.push_back('{1'b0, 32'hBEEF0010});
    mid();
    chk("cr_addr", ram_addr, 32'h10);
    chk("cr_we", 32'(ram_we), 0);
    chk("cr_stall", 32'(core_stall), 0);
    chk("cr_ubhw", 32'(ram_ubhw), 32'h4);
    next();
    idle();
    mid();
    chk("cr_rvalid", 32'(core_rvalid), 1);
    next();
    // debug write alone
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h40; dbg_wdata = 32'hDEADBEEF;
    mid();
    chk("dw_gnt", 32'(dbg_gnt), 1);
    chk("dw_we", 32'(ram_we), 1);
    chk("dw_ubhw", 32'(ram_ubhw), 32'h2);
    chk("dw_wdata", ram_wdata, 32'hDEADBEEF);
    chk("dw_addr", ram_addr, 32'h40);
    next();
    idle();
    mid();
    chk("dw_norv", 32'(dbg_rvalid), 0);
    next();
    // alternating reads
    core_req = 1; core_addr = 32'h8;
    sb.push_back('{1'b0, 32'hBEEF0008});
    next();
    idle();
    dbg_req = 1; dbg_addr = 32'hC;
    sb.push_back('{1'b1, 32'hBEEF000C});
    mid();
    chk("al_c1", 32'(core_rvalid), 1);
    chk("al_d1", 32'(dbg_rvalid), 0);
    next();
    idle();
    mid();
    chk("al_d2", 32'(dbg_rvalid), 1);
    chk("al_c2", 32'(core_rvalid), 0);
    chk("al_crd", core_rdata, 0);
    next();
    // debug read-back of the written word
    dbg_req = 1; dbg_addr = 32'h40;
    sb.push_back('{1'b1, 32'hDEADBEEF});
    mid();
    chk("dr_gnt", 32'(dbg_gnt), 1);
    next();
    idle();
    next();
    // sustained contention: debug forced through on the ninth contended cycle
    core_req = 1; core_addr = 32'h20; dbg_req = 1; dbg_addr = 32'h40;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) sb.push_back('{1'b1, 32'hDEADBEEF});
      else sb.push_back('{1'b0, 32'hBEEF0020});
      mid();
      chk("sc_stall", 32'(core_stall), 32'(c == 8));
      chk("sc_gnt", 32'(dbg_gnt), 32'(c == 8));
      chk("sc_addr", ram_addr, (c == 8) ? 32'h40 : 32'h20);
      next();
    end
    idle();
    next();
    next();
    // debug request dropped after 5 denied cycles, then re-asserted
    core_req = 1; core_addr = 32'h24; dbg_addr = 32'h40;
    for (int c = 0; c < 16; c++) begin
      dbg_req = !(c >= 5 && c < 7);
      if (c == 15) sb.push_back('{1'b1, 32'hDEADBEEF});
      else sb.push_back('{1'b0, 32'hBEEF0024});
      mid();
      chk("dd_gnt", 32'(dbg_gnt), 32'(c == 15));
      chk("dd_stall", 32'(core_stall), 32'(c == 15));
      next();
    end
    idle();
    next();
    next();
    // reset mid-read: the pending core response is discarded
    core_req = 1; core_addr = 32'h10;
    mid();
    chk("rm_stall", 32'(core_stall), 0);
    next();
    idle();
    rst = 0;
    #1;
    chk("rm_rv", 32'(core_rvalid), 0);
    mid();
    next();
    rst = 1;
    for (int c = 0; c < 2; c++) begin
      mid();
      chk("rm_crv", 32'(core_rvalid), 0);
      chk("rm_drv", 32'(dbg_rvalid), 0);
      chk("rm_stall2", 32'(core_stall), 0);
      chk("rm_gnt", 32'(dbg_gnt), 0);
      chk("rm_we", 32'(ram_we), 0);
      chk("rm_addr", ram_addr, 0);
      next();
    end
    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, synchronous-read data RAM between two requesters: the core MEM stage and a debug/loader master.
- The debug/loader master is used for program loading, memory inspection over the debug port, and future DMA.
- Sits between the EX/MEM pipeline register outputs and the data RAM.
- Grants one access per cycle, stalls the core when it loses arbitration, routes read data back to the right owner, and prevents debug starvation.

Parameters:
- ADDR_W, 32, address width of both requesters and the RAM.
- DATA_W, 32, data width.
- STARVE_LIMIT, 8, consecutive denied debug-request cycles before debug is forced to win; range 1..255.

Ports:
- clk  input  1  main clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; state clears while rst=0.
- core_req  input  1  core memory access this cycle (mem_r | mem_w of the MEM stage).
- core_we  input  1  core write enable.
- core_addr  input  ADDR_W  core byte address.
- core_wdata  input  DATA_W  core store data.
- core_ubhw  input  3  funct3 width/sign code of the core access.
- core_stall  output  1  core access not granted this cycle; pipeline must hold.
- core_rvalid  output  1  core read data valid.
- core_rdata  output  DATA_W  core read data.
- dbg_req  input  1  debug request; held until granted.
- dbg_we  input  1  debug write enable.
- dbg_addr  input  ADDR_W  debug byte address.
- dbg_wdata  input  DATA_W  debug write data.
- dbg_gnt  output  1  debug request accepted this cycle.
- dbg_rvalid  output  1  debug read data valid.
- dbg_rdata  output  DATA_W  debug read data.
- ram_addr  output  ADDR_W  RAM address.
- ram_wdata  output  DATA_W  RAM write data.
- ram_we  output  1  RAM write strobe.
- ram_ubhw  output  3  RAM width code.
- ram_rdata  input  DATA_W  RAM read data; valid one cycle after the address is issued.

Behaviour:
- **Grant rule** (combinational from current inputs and state):
  - Debug wins if dbg_req && (!core_req || starve_cnt == STARVE_LIMIT).
  - Otherwise, if core_req, the core wins.
  - At most one winner per cycle.
- **RAM drive** (combinational mux of the winner, no added latency):
  - Core winner: ram_* = core_* fields.
  - Debug winner: ram_addr = dbg_addr, ram_wdata = dbg_wdata, ram_we = dbg_we, ram_ubhw = 3'b010 (word only).
  - No winner: ram_addr = 0, ram_wdata = 0, ram_we = 0, ram_ubhw = 3'b010.
- **Handshake:**
  - core_stall = core_req && !core_win.
  - dbg_gnt = debug win, a single-cycle pulse per accepted request.
  - After dbg_gnt, the master may present a new request in the next cycle.
  - A write is complete at grant and produces no response.
- **Starve counter** (8-bit):
  - Increments when dbg_req && !dbg_gnt, saturating at STARVE_LIMIT.
  - Clears to 0 when dbg_gnt=1 or dbg_req=0.
- **Read-owner register** `owner`:
  - States: NONE, CORE, DBG.
  - Next state: CORE if the core won with !core_we; DBG if debug won with !dbg_we; otherwise NONE.
- **Read return:**
  - core_rvalid = (owner == CORE).
  - dbg_rvalid = (owner == DBG).
  - core_rdata = dbg_rdata = ram_rdata, qualified by the respective rvalid.
- Back-to-back reads from alternating owners return in issue order, one per cycle.
- **Reset (rst=0):**
  - starve_cnt = 0, owner = NONE.
  - core_rvalid = 0, dbg_rvalid = 0, dbg_gnt = 0, core_stall = 0, ram_we = 0.
- **Reset mid-read:** an in-flight read response is discarded and rvalid never asserts for it.
- **Simultaneous core and debug requests below the limit:** core wins; debug waits with its request held.
- **STARVE_LIMIT=1:** debug wins every other contended cycle.

Test Plan:
- **Core read alone:** core_req=1, we=0, addr=0x10 → same cycle ram_addr=0x10, ram_we=0, core_stall=0; next cycle core_rvalid=1, core_rdata=ram_rdata.
- **Sustained contention:** core_req=1 and dbg_req=1 held, STARVE_LIMIT=8 → core granted cycles 0..7; cycle 8 dbg_gnt=1, core_stall=1, ram_addr=dbg_addr; cycle 9 core wins again, starve_cnt=0.
- **Debug write alone:** dbg_req=1, dbg_we=1, addr=0x40, wdata=0xDEADBEEF → same cycle dbg_gnt=1, ram_we=1, ram_ubhw=3'b010, ram_wdata=0xDEADBEEF; next cycle dbg_rvalid=0.
- **Alternating reads:** core read 0x8 at cycle 0, debug read 0xC at cycle 1 → core_rvalid=1 only at cycle 1, dbg_rvalid=1 only at cycle 2, with the matching RAM data.
- **Reset mid-read:** core read issued at cycle 0, rst=0 asserted during cycle 0→1 → core_rvalid=0 immediately; after rst=1 all outputs stay at their idle values until a new request.
- **Debug request dropped:** dbg_req deasserted after 5 denied cycles → starve_cnt=0; re-asserted later → debug needs a further 8 contended cycles to win.
